// File: rtl/sin_tbl_sqrt.sv
// ============================================================================
// Module  : sin_tbl_sqrt (SIN_TBL_s11_s11, SQRT)
// Brief   : Registered quarter-wave sine lookup and 12-stage pipelined
//           integer square root for the FMCW sonar datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module SIN_TBL_s11_s11 (
    input  logic               CK_i,
    input  logic               XARST_i,
    input  logic        [11:0] DAT_i,
    output logic signed [11:0] SIN_o
);
    localparam int unsigned c_qtr_len = 1025;

    // round(2047*sin(pi*idx/2048)) via 2^30 fixed-point Taylor series
    function automatic logic [10:0] quarter_sin(input int idx);
        longint x;
        longint term;
        longint acc;
        longint scaled;
        x    = (64'sd3373259426 * longint'(idx)) / 64'sd2048;
        term = x;
        acc  = x;
        for (int n = 1; n <= 10; n++) begin
            term = (term * x) / 64'sd1073741824;
            term = (term * x) / 64'sd1073741824;
            term = -term / longint'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        scaled = (acc * 64'sd2047 + 64'sd536870912) / 64'sd1073741824;
        return 11'(scaled);
    endfunction

    logic        [10:0] w_qtr [c_qtr_len];
    logic        [10:0] w_idx;
    logic        [10:0] w_mag;
    logic signed [11:0] w_val;
    logic signed [11:0] r_sin;

    for (genvar gi = 0; gi < c_qtr_len; gi++) begin : g_qtr
        localparam logic [10:0] c_val = quarter_sin(gi);
        assign w_qtr[gi] = c_val;
    end

    // Second/fourth quadrants mirror the index; entry 1024 holds the peak
    always_comb begin
        w_idx = DAT_i[10] ? (11'd1024 - {1'b0, DAT_i[9:0]}) : {1'b0, DAT_i[9:0]};
        w_mag = w_qtr[w_idx];
        w_val = DAT_i[11] ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            r_sin <= '0;
        end else begin
            r_sin <= w_val;
        end
    end

    assign SIN_o = r_sin;
endmodule

module SQRT (
    input  logic        CK_i,
    input  logic        XARST_i,
    input  logic [22:0] DATs_i,
    output logic [11:0] QQs_o
);
    localparam int unsigned c_stages = 12;

    logic [23:0] r_rem      [c_stages];
    logic [11:0] r_root     [c_stages];
    logic [23:0] r_rad      [c_stages];
    logic [23:0] w_rem_in   [c_stages];
    logic [11:0] w_root_in  [c_stages];
    logic [23:0] w_rad_in   [c_stages];
    logic [23:0] w_acc      [c_stages];
    logic [23:0] w_try      [c_stages];
    logic [23:0] w_rem_nxt  [c_stages];
    logic [11:0] w_root_nxt [c_stages];
    logic [23:0] w_rad_nxt  [c_stages];

    always_comb begin
        w_rem_in[0]  = '0;
        w_root_in[0] = '0;
        w_rad_in[0]  = {1'b0, DATs_i};
        for (int k = 1; k < c_stages; k++) begin
            w_rem_in[k]  = r_rem[k-1];
            w_root_in[k] = r_root[k-1];
            w_rad_in[k]  = r_rad[k-1];
        end
        // One root bit per stage: try subtracting (4*root + 1) from the
        // remainder extended by the next radicand bit pair
        for (int k = 0; k < c_stages; k++) begin
            w_acc[k]     = {w_rem_in[k][21:0], w_rad_in[k][23:22]};
            w_try[k]     = {10'd0, w_root_in[k], 2'b01};
            w_rad_nxt[k] = {w_rad_in[k][21:0], 2'b00};
            if (w_acc[k] >= w_try[k]) begin
                w_rem_nxt[k]  = w_acc[k] - w_try[k];
                w_root_nxt[k] = {w_root_in[k][10:0], 1'b1};
            end else begin
                w_rem_nxt[k]  = w_acc[k];
                w_root_nxt[k] = {w_root_in[k][10:0], 1'b0};
            end
        end
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            for (int k = 0; k < c_stages; k++) begin
                r_rem[k]  <= '0;
                r_root[k] <= '0;
                r_rad[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < c_stages; k++) begin
                r_rem[k]  <= w_rem_nxt[k];
                r_root[k] <= w_root_nxt[k];
                r_rad[k]  <= w_rad_nxt[k];
            end
        end
    end

    assign QQs_o = r_root[c_stages-1];
endmodule

module sin_tbl_sqrt (
    input  logic               CK_i,
    input  logic               XARST_i,
    input  logic        [11:0] DAT_i,
    output logic signed [11:0] SIN_o,
    input  logic        [22:0] DATs_i,
    output logic        [11:0] QQs_o
);
    SIN_TBL_s11_s11 u_sin (
        .CK_i    (CK_i),
        .XARST_i (XARST_i),
        .DAT_i   (DAT_i),
        .SIN_o   (SIN_o)
    );

    SQRT u_sqrt (
        .CK_i    (CK_i),
        .XARST_i (XARST_i),
        .DATs_i  (DATs_i),
        .QQs_o   (QQs_o)
    );
endmodule

`default_nettype wire

// File: tb/tb_sin_tbl_sqrt.sv
// ============================================================================
// Module  : tb_sin_tbl_sqrt
// Brief   : Self-checking bench for the sine table and pipelined square root.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sin_tbl_sqrt;
    logic               CK_i = 1'b0;
    logic               XARST_i;
    logic        [11:0] DAT_i;
    logic signed [11:0] SIN_o;
    logic        [22:0] DATs_i;
    logic        [11:0] QQs_o;
    logic        [11:0] cos_dat;
    logic signed [11:0] cos_o;

    int n_cmp = 0;
    int n_bad = 0;
    int xq[$];
    int qlog[$];
    int sin_res[4096];
    bit cos_en = 1'b0;

    typedef struct { logic [11:0] dat; int exp; } sin_vec_t;
    typedef struct { int x; int q; } sqrt_vec_t;

    always #5 CK_i = ~CK_i;

    sin_tbl_sqrt dut (
        .CK_i    (CK_i),
        .XARST_i (XARST_i),
        .DAT_i   (DAT_i),
        .SIN_o   (SIN_o),
        .DATs_i  (DATs_i),
        .QQs_o   (QQs_o)
    );

    SIN_TBL_s11_s11 u_cos (
        .CK_i    (CK_i),
        .XARST_i (XARST_i),
        .DAT_i   (cos_dat),
        .SIN_o   (cos_o)
    );

    function automatic int sin_ref(input int p);
        real r;
        r = 2047.0 * $sin(2.0 * 3.14159265358979323846 * real'(p) / 4096.0);
        if (r >= 0.0) return int'($floor(r + 0.5));
        return -int'($floor(-r + 0.5));
    endfunction

    function automatic int isqrt(input longint x);
        int q;
        q = int'($floor($sqrt(real'(x))));
        while (longint'(q) * longint'(q) > x) q--;
        while ((longint'(q) + 1) * (longint'(q) + 1) <= x) q++;
        return q;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_model();
        xq.delete();
        for (int i = 0; i < 12; i++) xq.push_back(0);
    endtask

    // One clock: drive inputs, sample 1 time unit after the edge, check model
    task automatic step(input logic [11:0] p, input logic [22:0] x);
        int exp_sin;
        int exp_q;
        int sum;
        DAT_i   = p;
        DATs_i  = x;
        cos_dat = p - 12'd1024;
        @(posedge CK_i);
        #1;
        if (XARST_i) begin
            xq.push_back(int'(x));
            exp_sin = sin_ref(int'(p));
        end else begin
            xq.push_back(0);
            exp_sin = 0;
        end
        exp_q = isqrt(longint'(xq[1]));
        void'(xq.pop_front());
        chk("sin_model", int'(SIN_o), exp_sin);
        chk("sqrt_model", int'(QQs_o), exp_q);
        qlog.push_back(int'(QQs_o));
        if (cos_en) begin
            sum = int'(SIN_o) * int'(SIN_o) + int'(cos_o) * int'(cos_o);
            n_cmp++;
            if (sum < 2047 * 2047 - 2 * 2047 || sum > 2047 * 2047 + 2 * 2047) begin
                n_bad++;
                $display("FAIL quadrature: got s=%0d c=%0d sum=%0d required %0d +/- %0d",
                         SIN_o, cos_o, sum, 2047 * 2047, 2 * 2047);
            end
        end
    endtask

    initial begin
        sin_vec_t  sv[6];
        sqrt_vec_t qv[8];
        int base;
        int first_x;
        int at;
        int val;
        bit seen;
        logic [23:0] acc;

        sv[0] = '{12'h000, 0};     sv[1] = '{12'h200, 1447};
        sv[2] = '{12'h400, 2047};  sv[3] = '{12'h800, 0};
        sv[4] = '{12'hC00, -2047}; sv[5] = '{12'hE00, -1447};
        qv[0] = '{0, 0};       qv[1] = '{1, 1};       qv[2] = '{3, 1};
        qv[3] = '{4, 2};       qv[4] = '{15, 3};      qv[5] = '{16, 4};
        qv[6] = '{4194304, 2048}; qv[7] = '{8388607, 2896};

        XARST_i = 1'b0;
        DAT_i   = '0;
        DATs_i  = '0;
        cos_dat = '0;
        #12;
        chk("reset_sin", int'(SIN_o), 0);
        chk("reset_sqrt", int'(QQs_o), 0);
        @(negedge CK_i);
        XARST_i = 1'b1;
        clear_model();

        // Sine sweep against hand-computed amplitudes
        for (int i = 0; i < 6; i++) begin
            step(sv[i].dat, 23'd0);
            chk($sformatf("sin_vec_%03h", sv[i].dat), int'(SIN_o), sv[i].exp);
        end

        // Square-root exact values back-to-back, read 12 clocks later
        base = qlog.size();
        for (int i = 0; i < 8; i++) step(12'd0, 23'(qv[i].x));
        for (int i = 0; i < 12; i++) step(12'd0, 23'd0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("sqrt_vec_%0d", qv[i].x), qlog[base + i + 11], qv[i].q);

        // Full circle with random radicands in parallel
        for (int p = 0; p < 4096; p++) begin
            step(12'(p), 23'($urandom));
            sin_res[p] = int'(SIN_o);
        end
        for (int p = 0; p < 4096; p++) begin
            chk("sin_odd_sym", sin_res[p], -sin_res[(p + 2048) % 4096]);
            chk("sin_mirror_sym", sin_res[p], sin_res[(4096 + 2048 - p) % 4096]);
            chk("sin_not_min", int'(sin_res[p] == -2048), 0);
        end

        // Random stream for both blocks
        for (int i = 0; i < 10000; i++) step(12'($urandom), 23'($urandom));

        // Mid-stream reset: asynchronous clear, held for 3 clocks
        for (int i = 0; i < 20; i++) step(12'($urandom), 23'($urandom | 1));
        #2;
        XARST_i = 1'b0;
        #1;
        chk("rst_now_sin", int'(SIN_o), 0);
        chk("rst_now_sqrt", int'(QQs_o), 0);
        clear_model();
        for (int i = 0; i < 3; i++) step(12'($urandom), 23'($urandom | 1));
        @(negedge CK_i);
        XARST_i = 1'b1;
        seen    = 1'b0;
        at      = 0;
        val     = 0;
        first_x = int'($urandom_range(1, 8388607));
        for (int i = 0; i < 16; i++) begin
            step(12'($urandom), (i == 0) ? 23'(first_x) : 23'($urandom | 1));
            if (!seen && QQs_o != 12'd0) begin
                seen = 1'b1;
                at   = i + 1;
                val  = int'(QQs_o);
            end
        end
        chk("rst_first_lat", at, 12);
        chk("rst_first_val", val, isqrt(longint'(first_x)));

        // Quadrature pair from a phase accumulator
        acc    = 24'($urandom);
        cos_en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            acc = acc + 24'($urandom_range(1, 200000));
            step(acc[23:12], 23'($urandom));
        end
        cos_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
